// File: rtl/timebase_gen.sv
// Cascaded timebase: base tick at BASE_HZ, then three ripple-free divider stages.
// Optional manual tick input STEP when TIMEBASE_STEP_EN is defined.
module timebase_gen #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BASE_HZ = 100,
    parameter int DIV1    = 100,
    parameter int DIV2    = 60,
    parameter int DIV3    = 60
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    RUN,
    input  logic                    CLR,
`ifdef TIMEBASE_STEP_EN
    input  logic                    STEP,
`endif
    output logic                    EN_BASE,
    output logic                    EN1,
    output logic                    EN2,
    output logic                    EN3,
    output logic [$clog2(DIV1)-1:0] CNT1,
    output logic [$clog2(DIV2)-1:0] CNT2,
    output logic [$clog2(DIV3)-1:0] CNT3
);
    localparam int BASE_DIV = CLK_HZ / BASE_HZ;
    localparam int BW = (BASE_DIV >= 2) ? $clog2(BASE_DIV) : 1;
    localparam int W1 = $clog2(DIV1);
    localparam int W2 = $clog2(DIV2);
    localparam int W3 = $clog2(DIV3);

    localparam logic [BW-1:0] BMAX  = BW'(BASE_DIV - 1);
    localparam logic [W1-1:0] C1MAX = W1'(DIV1 - 1);
    localparam logic [W2-1:0] C2MAX = W2'(DIV2 - 1);
    localparam logic [W3-1:0] C3MAX = W3'(DIV3 - 1);

    generate
        if (BASE_DIV < 2) begin : g_bad_base
            $error("timebase_gen: BASE_DIV must be >= 2");
        end
        if (DIV1 < 2 || DIV2 < 2 || DIV3 < 2) begin : g_bad_div
            $error("timebase_gen: DIV1..DIV3 must be >= 2");
        end
    endgenerate

    logic step_w;
`ifdef TIMEBASE_STEP_EN
    assign step_w = STEP;
`else
    assign step_w = 1'b0;
`endif

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [W1-1:0] cnt1_q, cnt1_d;
    logic [W2-1:0] cnt2_q, cnt2_d;
    logic [W3-1:0] cnt3_q, cnt3_d;
    logic          en_base, en1, en2, en3;

    // STEP only acts as a manual base tick while the free-running count is stopped.
    always_comb begin
        en_base = ~RST & ~CLR & (RUN ? (bcnt_q == BMAX) : step_w);
        en1     = en_base & (cnt1_q == C1MAX);
        en2     = en1 & (cnt2_q == C2MAX);
        en3     = en2 & (cnt3_q == C3MAX);

        bcnt_d = bcnt_q;
        if (RUN)
            bcnt_d = (bcnt_q == BMAX) ? '0 : bcnt_q + BW'(1);
        else if (step_w)
            bcnt_d = '0;

        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        cnt3_d = cnt3_q;
        if (en_base) cnt1_d = (cnt1_q == C1MAX) ? '0 : cnt1_q + W1'(1);
        if (en1)     cnt2_d = (cnt2_q == C2MAX) ? '0 : cnt2_q + W2'(1);
        if (en2)     cnt3_d = (cnt3_q == C3MAX) ? '0 : cnt3_q + W3'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            bcnt_q <= '0;
            cnt1_q <= '0;
            cnt2_q <= '0;
            cnt3_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
            cnt3_q <= cnt3_d;
        end
    end

    assign EN_BASE = en_base;
    assign EN1     = en1;
    assign EN2     = en2;
    assign EN3     = en3;
    assign CNT1    = cnt1_q;
    assign CNT2    = cnt2_q;
    assign CNT3    = cnt3_q;
endmodule

// File: tb/tb_timebase_gen.sv
// Bench for timebase_gen: directed scenarios plus random RUN/CLR/RST/STEP traffic,
// all checked against a tick-count model (total base ticks, decoded arithmetically).
module tb_timebase_gen;
    localparam int CLK_HZ = 20, BASE_HZ = 4, D1 = 3, D2 = 2, D3 = 2;
    localparam int BD = CLK_HZ / BASE_HZ;
    localparam int P  = D1 * D2 * D3;

    logic       clk = 1'b0;
    logic       rst, run, clr, step;
    logic       en_base, en1, en2, en3;
    logic [1:0] cnt1;
    logic       cnt2, cnt3;

    always #5 clk = ~clk;

    timebase_gen #(.CLK_HZ(CLK_HZ), .BASE_HZ(BASE_HZ), .DIV1(D1), .DIV2(D2), .DIV3(D3)) dut (
        .CLK(clk), .RST(rst), .RUN(run), .CLR(clr),
`ifdef TIMEBASE_STEP_EN
        .STEP(step),
`endif
        .EN_BASE(en_base), .EN1(en1), .EN2(en2), .EN3(en3),
        .CNT1(cnt1), .CNT2(cnt2), .CNT3(cnt3)
    );

    int n_chk = 0, n_err = 0;
    int bph = 0;   // cycles into the current base period
    int tt  = 0;   // base ticks since last clear, modulo the full cascade period
    logic g_eb, g_e1, g_e2, g_e3;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check outputs at negedge, advance model, return at posedge+1.
    task automatic cyc(input logic r, input logic c, input logic ru, input logic st);
        logic st_e, eb, e1, e2, e3;
        rst = r; clr = c; run = ru; step = st;
`ifdef TIMEBASE_STEP_EN
        st_e = st;
`else
        st_e = 1'b0;
`endif
        eb = !r && !c && (ru ? (bph == BD - 1) : st_e);
        e1 = eb && (tt % D1 == D1 - 1);
        e2 = eb && ((tt + 1) % (D1 * D2) == 0);
        e3 = eb && ((tt + 1) % P == 0);
        @(negedge clk);
        g_eb = en_base; g_e1 = en1; g_e2 = en2; g_e3 = en3;
        chk("en_base", 32'(en_base), 32'(eb));
        chk("en1", 32'(en1), 32'(e1));
        chk("en2", 32'(en2), 32'(e2));
        chk("en3", 32'(en3), 32'(e3));
        chk("cnt1", 32'(cnt1), 32'(tt % D1));
        chk("cnt2", 32'(cnt2), 32'((tt / D1) % D2));
        chk("cnt3", 32'(cnt3), 32'((tt / (D1 * D2)) % D3));
        if (r || c) begin
            bph = 0; tt = 0;
        end else begin
            if (ru) bph = (bph + 1) % BD;
            else if (st_e) bph = 0;
            if (eb) tt = (tt + 1) % P;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_from_start(input string tag);
        int first_eb;
        first_eb = 0;
        for (int i = 1; i <= 60; i++) begin
            cyc(0, 0, 1, 0);
            if (g_eb && first_eb == 0) first_eb = i;
            if (i == 15) chk({tag, "_en1_c15"}, 32'(g_e1), 1);
            if (i == 30) chk({tag, "_en2_c30"}, 32'(g_e2), 1);
            if (i == 59) chk({tag, "_en3_c59"}, 32'(g_e3), 0);
            if (i == 60) chk({tag, "_all4_c60"}, {28'd0, g_eb, g_e1, g_e2, g_e3}, 32'hf);
        end
        chk({tag, "_first_eb"}, 32'(first_eb), 5);
    endtask

    initial begin
        int guard, lat;
        rst = 1; clr = 0; run = 0; step = 0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1, 0, 1, 0);
        chk("reset_cnt1", 32'(cnt1), 0);

        run_from_start("run");

        // Pause mid-period while BCNT=2
        guard = 0;
        while (bph != 2 && guard < 20) begin cyc(0, 0, 1, 0); guard++; end
        chk("pause_reach", 32'(bph), 2);
        repeat (7) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("resume_no_early", 32'(g_eb), 0);
        cyc(0, 0, 1, 0);
        chk("resume_eb", 32'(g_eb), 1);

        // Clear on a cycle that would fire EN_BASE and EN1
        guard = 0;
        while (!(bph == 4 && tt % D1 == 2) && guard < 100) begin cyc(0, 0, 1, 0); guard++; end
        chk("clr_reach", 32'(guard < 100), 1);
        cyc(0, 1, 1, 0);
        chk("clr_eb", 32'(g_eb), 0);
        chk("clr_e1", 32'(g_e1), 0);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, 1, 0);
            if (g_eb && lat == 0) lat = i;
        end
        chk("clr_latency", 32'(lat), 5);

        // Reset in the middle of operation
        guard = 0;
        while (!((tt / D1) % D2 == 1 && bph == 3) && guard < 100) begin cyc(0, 0, 1, 0); guard++; end
        chk("rst_reach", 32'(guard < 100), 1);
        cyc(1, 0, 1, 0);
        chk("rst_eb", 32'(g_eb), 0);
        run_from_start("rerun");

`ifdef TIMEBASE_STEP_EN
        cyc(0, 1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 0, 1);
            chk("step_eb", 32'(g_eb), 1);
            if (i == 3) chk("step_e1", 32'(g_e1), 1);
            cyc(0, 0, 0, 0);
        end
        chk("step_cnt1", 32'(cnt1), 0);
        cyc(0, 0, 1, 1);
        chk("step_ignored", 32'(g_eb), 0);
`endif

        for (int i = 0; i < 4000; i++)
            cyc(($urandom % 150) == 0, ($urandom % 60) == 0,
                ($urandom % 8) != 0, ($urandom % 3) == 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
